spi_slave_tx: RTL and testbench
===============================

# spi_slave_tx

SPI slave transmitter: serves 40-bit frames, MSB first, to the 5-byte SPI receive controller on the Basys3 side. It oversamples the master's SCLK and SS on its own faster system clock and drives MISO in SPI mode 0. The master samples MISO on SCLK rising edges; this block changes MISO on falling edges. Frames come from a valid/ready source. If no new word is pending, the last frame is re-sent.

## Interface
- FRAME_BITS, 40, bits per frame (5 bytes)
- clk  in  1  system clock; must be ≥ 8× SCLK frequency
- rst  in  1  synchronous, active-high reset
- SCLK  in  1  master serial clock, asynchronous to clk, idle low
- SS  in  1  master slave-select, active low, asynchronous to clk
- MISO  out  1  serial data to master
- din  in  FRAME_BITS  next frame to transmit
- din_valid  in  1  din holds a frame
- din_ready  out  1  pending buffer empty; a word is accepted when din_valid && din_ready
- busy  out  1  frame in progress (state SHIFT)
- frame_done  out  1  one-cycle pulse: full frame sent and SS released
- frame_abort  out  1  one-cycle pulse: SS released before FRAME_BITS rising edges

## Operation
- Synchronizers:
  - SCLK and SS each pass through 2 flip-flops, then a registered edge detector.
  - Signals produced: sclk_rise, sclk_fall, ss_fall, ss_rise (1-cycle pulses).
- Registers:
  - pend: pending frame, with pend_valid.
  - last: last frame loaded for transmit.
  - shreg: shift register, FRAME_BITS wide.
  - rcnt: count of rising edges, 6 bits.
- MISO = shreg[FRAME_BITS-1] at all times, from a register. There is no tristate.
- State IDLE:
  - Each cycle: shreg <= pend_valid ? pend : last. The MSB is therefore already on MISO before SS falls.
  - On ss_fall: go to SHIFT; rcnt <= 0; last <= shreg's loaded value; pend_valid <= 0 (the pending word is consumed).
- State SHIFT:
  - sclk_rise: rcnt <= rcnt+1, saturating at FRAME_BITS.
  - sclk_fall with rcnt < FRAME_BITS: shreg <= {shreg[FRAME_BITS-2:0], 1'b0}.
  - sclk_fall with rcnt == FRAME_BITS: ignored.
  - ss_rise: go to IDLE. Pulse frame_done if rcnt == FRAME_BITS, else pulse frame_abort.
  - An aborted frame is not retried. last keeps it, so it is re-sent only if no new word arrives.
- Handshake:
  - din_ready = !pend_valid.
  - Acceptance is allowed in any state; pend_valid <= 1 the next cycle.
  - A word accepted during SHIFT is used for the next frame.
- Simultaneous accept and ss_fall in the same cycle:
  - The frame uses the value preloaded before that cycle.
  - The new word stays pending (pend_valid = 1) for the next frame.
- ss_fall and ss_rise cannot coincide (single synchronized signal).
- Reset values: MISO 0, shreg 0, last 0, pend_valid 0, din_ready 1, busy 0, frame_done 0, frame_abort 0, rcnt 0, state IDLE.

## Timing
- Input-to-pulse latency: 3 clk from an SCLK/SS pin edge to its pulse (2 sync + 1 edge register).
- MISO update: 1 clk after sclk_fall, so 4 clk after the pin falling edge.
- Requirement: SCLK half-period ≥ 4 clk. This keeps MISO stable before the next rising edge.
- First bit: the MSB is valid on MISO while SS is high and ≥ 1 clk before SS falls. This holds if din was accepted ≥ 2 clk before the SS pin falls; otherwise `last` is sent.
- frame_done/frame_abort: 4 clk after the SS pin rising edge.
- din_ready: low 1 clk after acceptance; high again 1 clk after ss_fall consumes pend.
- rst mid-frame:
  - Return to IDLE, MISO 0, no done/abort pulse.
  - A master still in a frame receives zeros for the remainder.

## Structure
- Package spi_pkg:
  - FRAME_BITS localparam (40), shared with the receive controller.
  - State enum {IDLE, SHIFT}.
- Sub-module sync_edge:
  - 2-FF synchronizer plus edge-detect register; outputs rise/fall pulses and the synced level.
  - Instantiated twice (SCLK, SS).
- Top-level spi_slave_tx holds the handshake buffer, shift register, counter and FSM.

## Test plan
- Reset: hold rst 3 cycles → MISO=0, din_ready=1, busy=0, no pulses. Run a master frame with no din → master captures 40'h0.
- Single frame: accept din=40'hA5_0F_C3_3C_81; master-model frame at clk/8 → captures 40'hA50FC33C81, frame_done pulses once, din_ready returns high 1 clk after ss_fall.
- Repeat: no new din, second frame → captures 40'hA50FC33C81 again.
- Back-to-back: accept 40'h11_22_33_44_55 during SHIFT of the previous frame → current frame unaffected; next frame captures 40'h1122334455.
- Abort: SS released after 20 rising edges → frame_abort pulses, no frame_done. Next frame starts at MSB of pend (if pending) or last.
- rst at rising edge 17 → state IDLE, MISO=0, pend_valid=0. A following frame with din=40'hFF_FF_FF_FF_FF captures that value.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI frame definitions for the slave transmitter and the receive controller.
package spi_pkg;

  localparam int unsigned FRAME_BITS = 40;
  localparam int unsigned CNT_W      = 6;

  typedef logic [FRAME_BITS-1:0] frame_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/spi_slave_tx_if.sv
// SPI pins plus the frame valid/ready source and status outputs of spi_slave_tx.
interface spi_slave_tx_if;
  import spi_pkg::*;

  logic   SCLK;
  logic   SS;
  logic   MISO;
  frame_t din;
  logic   din_valid;
  logic   din_ready;
  logic   busy;
  logic   frame_done;
  logic   frame_abort;

  modport master (
    output SCLK, SS, din, din_valid,
    input  MISO, din_ready, busy, frame_done, frame_abort
  );

  modport slave (
    input  SCLK, SS, din, din_valid,
    output MISO, din_ready, busy, frame_done, frame_abort
  );

endinterface

// File: rtl/spi_slave_tx_sync_edge.sv
// Two-flop synchronizer followed by a registered rise/fall edge detector.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic rise_q;
  logic fall_q;

  // Level chain keeps tracking the pin through reset so a release mid-frame
  // does not fabricate an edge from a stale reset value.
  always_ff @(posedge clk) begin
    meta_q <= async_i;
    sync_q <= meta_q;
    prev_q <= sync_q;
  end

  // One-cycle edge pulses from the synchronized level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= sync_q & ~prev_q;
      fall_q <= ~sync_q & prev_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/spi_slave_tx.sv
// SPI mode-0 slave transmitter: 40-bit frames MSB first from a valid/ready source,
// re-sending the last frame when nothing new is pending.
module spi_slave_tx
  import spi_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  spi_slave_tx_if.slave  bus
);

  localparam logic [CNT_W-1:0] RCNT_MAX = CNT_W'(FRAME_BITS);

  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic ss_rise, ss_fall, ss_lvl_unused;

  state_e            state_q, state_d;
  frame_t            shreg_q, shreg_d;
  frame_t            last_q, last_d;
  frame_t            pend_q, pend_d;
  logic              pend_valid_q, pend_valid_d;
  logic              loaded_pend_q, loaded_pend_d;
  logic              din_ready_q, din_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;
  logic [CNT_W-1:0]  rcnt_q, rcnt_d;
  logic              accept_c;

  sync_edge u_sclk_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (bus.SCLK),
    .level_o (sclk_lvl_unused),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  sync_edge u_ss_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (bus.SS),
    .level_o (ss_lvl_unused),
    .rise_o  (ss_rise),
    .fall_o  (ss_fall)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      last_q        <= '0;
      pend_q        <= '0;
      pend_valid_q  <= 1'b0;
      loaded_pend_q <= 1'b0;
      din_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      abort_q       <= 1'b0;
      rcnt_q        <= '0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      last_q        <= last_d;
      pend_q        <= pend_d;
      pend_valid_q  <= pend_valid_d;
      loaded_pend_q <= loaded_pend_d;
      din_ready_q   <= din_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      abort_q       <= abort_d;
      rcnt_q        <= rcnt_d;
    end
  end

  // Next-state: preload in IDLE, shift on SCLK falls in SHIFT, pending-word handshake.
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    last_d        = last_q;
    pend_d        = pend_q;
    pend_valid_d  = pend_valid_q;
    loaded_pend_d = loaded_pend_q;
    rcnt_d        = rcnt_q;
    done_d        = 1'b0;
    abort_d       = 1'b0;
    accept_c      = bus.din_valid && din_ready_q;

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          // Frame goes out with whatever is already preloaded; the pending
          // word is only consumed if it is the one that was preloaded.
          state_d = SHIFT;
          rcnt_d  = '0;
          last_d  = shreg_q;
          if (loaded_pend_q) begin
            pend_valid_d = 1'b0;
          end
        end else begin
          shreg_d       = pend_valid_q ? pend_q : last_q;
          loaded_pend_d = pend_valid_q;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_d = IDLE;
          if (rcnt_q == RCNT_MAX) begin
            done_d = 1'b1;
          end else begin
            abort_d = 1'b1;
          end
        end else if (sclk_rise) begin
          if (rcnt_q != RCNT_MAX) begin
            rcnt_d = rcnt_q + CNT_W'(1);
          end
        end else if (sclk_fall && (rcnt_q < RCNT_MAX)) begin
          shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept_c) begin
      pend_d       = bus.din;
      pend_valid_d = 1'b1;
    end

    din_ready_d = !pend_valid_d;
    busy_d      = (state_d == SHIFT);
  end

  assign bus.MISO        = shreg_q[FRAME_BITS-1];
  assign bus.din_ready   = din_ready_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = done_q;
  assign bus.frame_abort = abort_q;

endmodule

// File: tb/tb_spi_slave_tx.sv
// Directed plus randomized frames from a mode-0 master model, scored against a
// frame-level model of the pending/last word rules.
module tb_spi_slave_tx;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_slave_tx_if bus();

  spi_slave_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;
  int unsigned fail_cnt  = 0;
  int unsigned done_seen = 0;
  int unsigned abort_seen = 0;

  // Frame-level reference: one pending slot and the last frame sent.
  frame_t m_pend;
  frame_t m_last;
  bit     m_pend_v;

  // Pulse counters observed on the bus.
  always @(posedge clk) begin
    if (bus.frame_done === 1'b1)  done_seen  <= done_seen + 1;
    if (bus.frame_abort === 1'b1) abort_seen <= abort_seen + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input frame_t w, input string tag);
    @(negedge clk);
    chk({tag, "_rdy_hi"}, 64'(bus.din_ready), 64'(1));
    bus.din       = w;
    bus.din_valid = 1'b1;
    @(negedge clk);
    bus.din_valid = 1'b0;
    chk({tag, "_rdy_lo"}, 64'(bus.din_ready), 64'(0));
    m_pend   = w;
    m_pend_v = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_frame(input int nrise, input int push_at, input frame_t push_w,
                           input int rst_at, input string tag);
    frame_t      sent;
    frame_t      cap;
    frame_t      expc;
    bit          had_pend;
    bit          rst_hit;
    int unsigned d0;
    int unsigned a0;
    cap      = '0;
    expc     = '0;
    rst_hit  = 1'b0;
    had_pend = m_pend_v;
    sent     = m_pend_v ? m_pend : m_last;
    chk({tag, "_msb_pre"}, 64'(bus.MISO), 64'(sent[FRAME_BITS-1]));
    @(negedge clk);
    bus.SS = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, "_rdy_before"}, 64'(bus.din_ready), 64'(!had_pend));
    @(negedge clk);
    chk({tag, "_rdy_after"}, 64'(bus.din_ready), 64'(1));
    chk({tag, "_busy"}, 64'(bus.busy), 64'(1));
    m_last   = sent;
    m_pend_v = 1'b0;
    for (int i = 0; i < nrise; i++) begin
      cap  = {cap[FRAME_BITS-2:0], bus.MISO};
      expc = {expc[FRAME_BITS-2:0], rst_hit ? 1'b0 : sent[FRAME_BITS-1-i]};
      bus.SCLK = 1'b1;
      if (i == push_at) begin
        chk({tag, "_shift_rdy"}, 64'(bus.din_ready), 64'(1));
        bus.din       = push_w;
        bus.din_valid = 1'b1;
        @(negedge clk);
        bus.din_valid = 1'b0;
        chk({tag, "_shift_acc"}, 64'(bus.din_ready), 64'(0));
        m_pend   = push_w;
        m_pend_v = 1'b1;
        repeat (3) @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
      if (i == rst_at) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk({tag, "_rst_miso"}, 64'(bus.MISO), 64'(0));
        chk({tag, "_rst_busy"}, 64'(bus.busy), 64'(0));
        chk({tag, "_rst_rdy"}, 64'(bus.din_ready), 64'(1));
        m_pend_v = 1'b0;
        m_last   = '0;
        rst_hit  = 1'b1;
      end
      bus.SCLK = 1'b0;
      repeat (4) @(negedge clk);
    end
    chk({tag, "_data"}, 64'(cap), 64'(expc));
    d0 = done_seen;
    a0 = abort_seen;
    bus.SS = 1'b1;
    repeat (3) @(negedge clk);
    chk({tag, "_early_pulse"}, 64'({bus.frame_done, bus.frame_abort}), 64'(0));
    @(negedge clk);
    chk({tag, "_pulse"}, 64'({bus.frame_done, bus.frame_abort}),
        64'({!rst_hit && nrise >= int'(FRAME_BITS), !rst_hit && nrise < int'(FRAME_BITS)}));
    chk({tag, "_idle"}, 64'(bus.busy), 64'(0));
    repeat (4) @(negedge clk);
    chk({tag, "_npulse"}, 64'({done_seen - d0, abort_seen - a0}),
        64'({32'(!rst_hit && nrise >= int'(FRAME_BITS)), 32'(!rst_hit && nrise < int'(FRAME_BITS))}));
  endtask

  initial begin
    frame_t w;
    int     nr;
    int     pa;
    rst           = 1'b1;
    bus.SCLK      = 1'b0;
    bus.SS        = 1'b1;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    m_pend        = '0;
    m_last        = '0;
    m_pend_v      = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_miso", 64'(bus.MISO), 64'(0));
    chk("reset_rdy", 64'(bus.din_ready), 64'(1));
    chk("reset_busy", 64'(bus.busy), 64'(0));
    chk("reset_pulses", 64'({bus.frame_done, bus.frame_abort}), 64'(0));
    rst = 1'b0;
    repeat (4) @(negedge clk);

    run_frame(40, -1, '0, -1, "empty");
    push(40'hA5_0F_C3_3C_81, "single_push");
    run_frame(40, -1, '0, -1, "single");
    run_frame(40, -1, '0, -1, "repeat");
    run_frame(40, 10, 40'h11_22_33_44_55, -1, "b2b_cur");
    run_frame(40, -1, '0, -1, "b2b_next");
    run_frame(20, -1, '0, -1, "abort");
    run_frame(40, -1, '0, -1, "after_abort");
    push(40'hDE_AD_BE_EF_01, "abort2_push");
    run_frame(20, -1, '0, -1, "abort_pend");
    run_frame(40, -1, '0, -1, "abort_resend");
    push(40'h0F_0F_0F_0F_0F, "midrst_push");
    run_frame(40, 5, 40'h77_66_55_44_33, 16, "midrst");
    push(40'hFF_FF_FF_FF_FF, "ff_push");
    run_frame(40, -1, '0, -1, "ff");

    for (int it = 0; it < 8; it++) begin
      if (!m_pend_v && ($urandom_range(0, 1) == 1)) begin
        w = {8'($urandom()), $urandom()};
        push(w, $sformatf("rnd%0d_push", it));
      end
      nr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 39)) : 40;
      pa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nr - 1)) : -1;
      w  = {8'($urandom()), $urandom()};
      run_frame(nr, pa, w, -1, $sformatf("rnd%0d", it));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
